gray_conv_sched: RTL and testbench
==================================

// Module: gray_conv_sched
// PURPOSE
//  Round-robin scheduler sharing one gray<->binary conversion engine among NREQ requesters.
//  Per-request mode selects the direction:
//    - gray->binary: computed bit-serially, MSB first, one bit per cycle.
//    - binary->gray: computed in one cycle.
//  Accepts one request at a time, registers the result and returns it with the requester id.
//  Output uses a valid/ready handshake.
// PARAMETERS
//  W     4  data width in bits (>=1)
//  NREQ  4  number of requesters (>=1); IDW = (NREQ>1) ? $clog2(NREQ) : 1
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  req_valid  in   NREQ     request i pending
//  req_mode   in   NREQ     bit i: 0 = gray->binary, 1 = binary->gray
//  req_data   in   NREQ*W   operand i in bits [i*W +: W]
//  req_ready  out  NREQ     one-hot accept strobe for requester i
//  out_valid  out  1        result available
//  out_ready  in   1        consumer takes result
//  out_data   out  W        converted value
//  out_id     out  IDW      index of the requester that produced out_data
//  busy       out  1        high when state != IDLE
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, rr pointer 0, out_valid 0, out_data 0, out_id 0,
//    busy 0, req_ready 0. Reset mid-operation aborts the job; no out_valid is produced.
//  - States: IDLE, CONV, DONE.
//  - IDLE:
//    - Grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ.
//    - req_ready[i]=1 combinationally, only in IDLE, only for the grantee.
//    - The accept edge latches data, mode and id.
//    - Requesters hold valid and data until ready; dropping valid before grant is legal.
//  - Binary->gray (mode 1): accept edge writes out_data = d ^ (d >> 1) -> DONE. Latency 1 edge.
//  - Gray->binary (mode 0):
//    - Accept edge sets b[W-1] = g[W-1] and bit counter = W-2, then enters CONV
//      (goes straight to DONE if W=1).
//    - Each CONV edge sets b[cnt] = b[cnt+1] ^ g[cnt] and decrements cnt.
//    - The edge with cnt=0 enters DONE.
//    - Latency: W edges from accept to out_valid=1.
//    - out_data bits not yet computed are don't-care until DONE.
//  - DONE:
//    - out_valid=1; out_data and out_id held stable until out_valid && out_ready.
//    - On that edge: go to IDLE, out_valid 0, ptr = (out_id+1) mod NREQ.
//    - No request is accepted in the same cycle as an output handshake.
//    - Minimum spacing between accepts is L+1 cycles.
//  - out_ready while out_valid=0 is ignored. req_valid outside IDLE is ignored (ready stays 0).
//  - All requesters active: grants rotate 0,1,2,...,NREQ-1,0 (no starvation).
//  - NREQ=1: ptr is constant 0; out_id is always 0.
// CONFIGURATION
//  GCONV_FAST_EN defined:
//    - Gray->binary is computed combinationally on the accept edge (prefix XOR).
//    - The accept edge goes straight to DONE; latency 1 for both modes.
//    - CONV state and bit counter are not built.
//  GCONV_FAST_EN undefined: bit-serial gray->binary as above (latency W).
//  Results are bit-identical in both builds.
// TESTING (W=4, NREQ=4)
//  1. req0 mode0 data 4'b1101 -> req_ready[0] one cycle; out_data 4'b1001, out_id 0;
//     out_valid 4 edges after accept (1 edge with GCONV_FAST_EN).
//  2. req2 mode1 data 4'b1011 -> out_data 4'b1110, out_id 2, out_valid 1 edge after accept.
//  3. All four req_valid held high, out_ready=1 -> accept order 0,1,2,3,0; exactly one
//     req_ready bit per accept; busy low only in the IDLE cycles.
//  4. out_ready low 5 cycles in DONE -> out_valid, out_data, out_id stable; req_ready stays 0;
//     out_ready=1 -> IDLE, next grant to id+1.
//  5. rst pulse during CONV (after 2 edges) -> all outputs at reset values immediately;
//     next request from req3 and req0 together -> req0 granted (ptr 0).
//  6. Exhaustive: values 0..15 in both modes through requester 1; check against reference
//     XOR model; g2b(b2g(x)) == x for every x.

Source files
------------

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one gray<->binary converter among NREQ requesters.
// Optional build macro GCONV_FAST_EN: gray->binary is computed in one edge instead of bit-serially.
module gray_conv_sched #(
    parameter  int W    = 4,
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_mode,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [IDW-1:0]    out_id,
    output logic              busy
);

`ifdef GCONV_FAST_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int            CW        = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_START = (W > 1) ? CW'(W - 2) : '0;
`endif

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef GCONV_FAST_EN
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    function automatic int wrap_idx(input int base, input int k);
        int s;
        s = base + k;
        return (s >= NREQ) ? (s - NREQ) : s;
    endfunction

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              out_valid_q;
    logic [W-1:0]      out_data_q, out_data_d;
    logic [IDW-1:0]    out_id_q, out_id_d;
    logic              busy_q;
`ifndef GCONV_FAST_EN
    logic [W-1:0]      g_q, g_d;
    logic [CW-1:0]     cnt_q, cnt_d;
`endif

    logic              grant_found_s;
    logic [IDW-1:0]    grant_idx_s;
    logic [W-1:0]      sel_data_s;
    logic              sel_mode_s;
    logic              accept_s;

    // Round-robin search starting at ptr; captures the grantee's operand and mode.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        sel_data_s    = '0;
        sel_mode_s    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found_s && req_valid[wrap_idx(int'(ptr_q), k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IDW'(wrap_idx(int'(ptr_q), k));
                sel_data_s    = req_data[wrap_idx(int'(ptr_q), k)*W +: W];
                sel_mode_s    = req_mode[wrap_idx(int'(ptr_q), k)];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign accept_s = (state_q == IDLE) && grant_found_s;

    // One-hot accept strobe, forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (accept_s && !rst) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and datapath update for the IDLE -> (CONV) -> DONE sequence.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
`ifndef GCONV_FAST_EN
        g_d        = g_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    out_id_d = grant_idx_s;
                    if (sel_mode_s) begin
                        out_data_d = bin2gray(sel_data_s);
                        state_d    = DONE;
                    end else begin
`ifdef GCONV_FAST_EN
                        out_data_d = gray2bin(sel_data_s);
                        state_d    = DONE;
`else
                        // MSB of the binary result equals the gray MSB; the rest follow serially.
                        g_d             = sel_data_s;
                        out_data_d      = '0;
                        out_data_d[W-1] = sel_data_s[W-1];
                        cnt_d           = CNT_START;
                        state_d         = (W == 1) ? DONE : CONV;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
`ifndef GCONV_FAST_EN
            CONV: begin
                for (int i = 0; i < W - 1; i++) begin
                    out_data_d[i] = (cnt_q == CW'(i)) ? (out_data_q[i+1] ^ g_q[i]) : out_data_q[i];
                end
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? DONE : CONV;
            end
`endif
            DONE: begin
                // out_valid is high for the whole of DONE, so out_ready alone completes the handshake.
                if (out_ready) begin
                    state_d = IDLE;
                    ptr_d   = (out_id_q == IDW'(NREQ - 1)) ? '0 : (out_id_q + IDW'(1));
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; valid and busy are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            busy_q      <= 1'b0;
`ifndef GCONV_FAST_EN
            g_q         <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= (state_d == DONE);
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            busy_q      <= (state_d != IDLE);
`ifndef GCONV_FAST_EN
            g_q         <= g_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gray_conv_sched.sv
// Randomized self-checking bench for gray_conv_sched (W=4, NREQ=4) against an arithmetic reference.
module tb_gray_conv_sched;

    localparam int W    = 4;
    localparam int NREQ = 4;
`ifdef GCONV_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_mode;
    logic [15:0]   req_data;
    logic [3:0]    req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_data;
    logic [1:0]    out_id;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int ptr      = 0;

    gray_conv_sched #(.W(W), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_b2g(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

    // Binary value is the XOR of every right shift of the gray code.
    function automatic logic [3:0] ref_g2b(input logic [3:0] g);
        logic [3:0] b;
        logic [3:0] s;
        b = g;
        s = g >> 1;
        while (s != 4'd0) begin
            b = b ^ s;
            s = s >> 1;
        end
        return b;
    endfunction

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    // One full transaction: grant, latency, result, optional DONE stall, handshake.
    task automatic run_one(input logic [3:0] v, input logic [3:0] m, input logic [15:0] d,
                           input int hold, output logic [3:0] res, output int gid);
        int         g;
        int         lat;
        int         exp_lat;
        logic [3:0] din;
        logic [3:0] exp_d;
        req_valid = v;
        req_mode  = m;
        req_data  = d;
        out_ready = 1'b0;
        #1;
        g       = model_grant(v);
        din     = d[g*4 +: 4];
        exp_d   = m[g] ? ref_b2g(din) : ref_g2b(din);
        exp_lat = (m[g] || FAST) ? 1 : W;
        check_value("grant", 32'(req_ready), 32'(1) << g);
        check_value("busy_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_value("ready_after_accept", 32'(req_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 64) begin
            check_value("busy_conv", 32'(busy), 32'd1);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        check_value("latency", 32'(lat), 32'(exp_lat));
        check_value("out_data", 32'(out_data), 32'(exp_d));
        check_value("out_id", 32'(out_id), 32'(g));
        check_value("busy_done", 32'(busy), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_value("hold_valid", 32'(out_valid), 32'd1);
            check_value("hold_data", 32'(out_data), 32'(exp_d));
            check_value("hold_id", 32'(out_id), 32'(g));
            check_value("hold_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_value("hs_valid", 32'(out_valid), 32'd0);
        check_value("hs_busy", 32'(busy), 32'd0);
        ptr = (g + 1) % NREQ;
        res = exp_d;
        gid = g;
    endtask

    initial begin
        logic [3:0]  r;
        logic [3:0]  y;
        logic [3:0]  z;
        int          id;
        int          first_id;
        logic [3:0]  rv;
        logic [3:0]  rm;
        logic [15:0] rd;

        rst       = 1'b1;
        req_valid = 4'd0;
        req_mode  = 4'd0;
        req_data  = 16'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_valid", 32'(out_valid), 32'd0);
        check_value("rst_data", 32'(out_data), 32'd0);
        check_value("rst_id", 32'(out_id), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Gray->binary through requester 0.
        run_one(4'b0001, 4'b0000, 16'h000D, 0, r, id);
        check_value("t1_data", 32'(r), 32'h9);
        check_value("t1_id", 32'(id), 32'd0);

        // Binary->gray through requester 2.
        run_one(4'b0100, 4'b0100, 16'h0B00, 0, r, id);
        check_value("t2_data", 32'(r), 32'hE);
        check_value("t2_id", 32'(id), 32'd2);

        // Stall in DONE for five cycles, then the next grant moves past the served id.
        run_one(4'b0010, 4'b0010, 16'h0050, 5, r, id);
        check_value("t4_id", 32'(id), 32'd1);
        run_one(4'b1111, 4'b0000, 16'h1234, 0, r, id);
        check_value("t4_next", 32'(id), 32'd2);

        // Reset in the middle of a job aborts it and returns the pointer to 0.
        req_valid = 4'b0001;
        req_mode  = 4'b0000;
        req_data  = 16'h0006;
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_value("t5_valid", 32'(out_valid), 32'd0);
        check_value("t5_data", 32'(out_data), 32'd0);
        check_value("t5_id", 32'(out_id), 32'd0);
        check_value("t5_busy", 32'(busy), 32'd0);
        check_value("t5_ready", 32'(req_ready), 32'd0);
        req_valid = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ptr = 0;
        repeat (W + 1) begin
            @(posedge clk);
            #1;
            check_value("t5_no_valid", 32'(out_valid), 32'd0);
        end
        run_one(4'b1001, 4'b0000, 16'h3005, 0, r, id);
        check_value("t5_grant0", 32'(id), 32'd0);

        // All requesters pending: grants rotate one step per accept.
        for (int k = 0; k < 5; k++) begin
            run_one(4'b1111, 4'($urandom), 16'($urandom), 0, r, id);
            if (k == 0) first_id = id;
            check_value("t3_rotate", 32'(id), 32'((first_id + k) % NREQ));
        end

        // Exhaustive values through requester 1 in both directions, plus round trip.
        for (int x = 0; x < 16; x++) begin
            run_one(4'b0010, 4'b0010, 16'(x) << 4, 0, y, id);
            run_one(4'b0010, 4'b0000, 16'(y) << 4, 0, z, id);
            check_value("roundtrip", 32'(z), 32'(x));
            run_one(4'b0010, 4'b0000, 16'(x) << 4, 0, r, id);
        end

        // Random mixes of pending requesters, modes, operands and DONE stalls.
        for (int n = 0; n < 40; n++) begin
            rv = 4'($urandom_range(1, 15));
            rm = 4'($urandom);
            rd = 16'($urandom);
            run_one(rv, rm, rd, $urandom_range(0, 3), r, id);
        end

        req_valid = 4'd0;
        @(posedge clk);
        #1;
        check_value("end_idle_busy", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
